// File: rtl/mips_pkg.sv
// Shared types and constants for the memory-port arbiter.
// Holds the arbiter state encoding, default bus widths and owner codes.
package mips_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

endpackage

// File: rtl/arb_watchdog.sv
// Transaction watchdog: counts BUSY cycles since clear and flags the last allowed one.
// expire_o is high for the single cycle in which the count reaches TIMEOUT-1.
module arb_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LAST)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = en_i & ~clr_i & (cnt_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory between instruction fetch and data access.
// Data wins ties, but fetch is guaranteed a grant after STARVE_MAX back-to-back data grants.
//
// state   | meaning
// IDLE    | no transaction; pick a requester and latch its command
// BUSY_IF | fetch in flight, waiting for mem_ready or watchdog
// BUSY_DM | load/store in flight, waiting for mem_ready or watchdog
// DONE    | one-cycle ack (and err) to the owner, requests ignored
module mem_port_arbiter
  import mips_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int TIMEOUT    = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              dm_read,
  input  logic              dm_write,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ack,
  output logic              err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              stall_if,
  output logic              stall_mem
);

  localparam int STRK_W = $clog2(STARVE_MAX + 1);
  localparam logic [STRK_W-1:0] STRK_MAX = STRK_W'(STARVE_MAX);

  arb_state_t        state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic              err_pend_q, err_pend_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [STRK_W-1:0] streak_q, streak_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              if_ack_q, if_ack_d;
  logic              dm_ack_q, dm_ack_d;
  logic              err_q, err_d;
  logic              dm_pend, busy, wdog_expire;

  assign dm_pend = dm_read | dm_write;
  assign busy    = (state_q == BUSY_IF) || (state_q == BUSY_DM);

  arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (~busy),
    .en_i     (busy),
    .expire_o (wdog_expire)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    err_pend_d = err_pend_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    streak_d   = streak_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;
    if_ack_d   = 1'b0;
    dm_ack_d   = 1'b0;
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (dm_pend && !((streak_q == STRK_MAX) && if_req)) begin
          state_d    = BUSY_DM;
          owner_d    = OWN_DM;
          addr_d     = dm_addr;
          wdata_d    = dm_wdata;
          we_d       = dm_write;
          // read+write together is executed as a store but reported as an error
          err_pend_d = dm_read & dm_write;
          if (!if_req) begin
            streak_d = '0;
          end else if (streak_q != STRK_MAX) begin
            streak_d = streak_q + 1'b1;
          end
        end else if (if_req) begin
          state_d    = BUSY_IF;
          owner_d    = OWN_IF;
          addr_d     = if_addr;
          wdata_d    = '0;
          we_d       = 1'b0;
          err_pend_d = 1'b0;
          streak_d   = '0;
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (mem_ready) begin
          state_d = DONE;
          if (owner_q == OWN_IF) begin
            if_rdata_d = mem_rdata;
          end else if (!we_q) begin
            dm_rdata_d = mem_rdata;
          end
        end else if (wdog_expire) begin
          state_d    = DONE;
          err_pend_d = 1'b1;
          if (owner_q == OWN_IF) begin
            if_rdata_d = '0;
          end else begin
            dm_rdata_d = '0;
          end
        end
        if (state_d == DONE) begin
          if_ack_d = (owner_q == OWN_IF);
          dm_ack_d = (owner_q == OWN_DM);
          err_d    = err_pend_d;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      we_q       <= 1'b0;
      err_pend_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      streak_q   <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      err_pend_q <= err_pend_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      streak_q   <= streak_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
      if_ack_q   <= if_ack_d;
      dm_ack_q   <= dm_ack_d;
      err_q      <= err_d;
    end
  end

  assign mem_en    = busy;
  assign mem_we    = busy & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_ack    = if_ack_q;
  assign dm_ack    = dm_ack_q;
  assign err       = err_q;
  assign stall_if  = if_req & ~if_ack_q;
  assign stall_mem = dm_pend & ~dm_ack_q;

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares one single-ported, variable-latency unified memory between the IF stage (instruction fetch) and the MEM stage (lw/sw) of the five-stage pipeline.
- Arbitrates with data priority and a bounded-starvation guarantee for fetch.
- Sequences each memory transaction with a ready handshake and a watchdog timeout.
- Produces the per-stage stall lines consumed by the pipeline register enables.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TIMEOUT, 64, max BUSY cycles without mem_ready before abort (≥2)
- STARVE_MAX, 4, consecutive DM grants allowed while if_req pending (≥1)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request (level)
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched instruction, registered
- if_ack  out  1  one-cycle completion pulse, fetch
- dm_read  in  1  load request (MemRead)
- dm_write  in  1  store request (MemWrite)
- dm_addr  in  ADDR_W  data address (ALU result)
- dm_wdata  in  DATA_W  store data
- dm_rdata  out  DATA_W  load data, registered
- dm_ack  out  1  one-cycle completion pulse, data
- err  out  1  pulses with ack when that transaction timed out or was illegal
- mem_en  out  1  memory access strobe
- mem_we  out  1  write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready
- mem_ready  in  1  transaction complete
- stall_if  out  1  freeze PC and IF/ID register
- stall_mem  out  1  freeze EX/MEM and earlier stages

## Operation
- States: IDLE, BUSY_IF, BUSY_DM, DONE.
- IDLE:
  - DM pending = dm_read|dm_write.
  - Grant DM if pending, unless streak == STARVE_MAX and if_req = 1; then grant IF.
  - Otherwise grant IF if if_req.
  - On grant, latch address, wdata and we into registers; go to BUSY_x.
- BUSY_x:
  - mem_en = 1; mem_we/addr/wdata come from the latched registers, stable for the whole transaction.
  - On mem_ready: capture mem_rdata into if_rdata or dm_rdata (store: dm_rdata unchanged); go to DONE.
  - On wdog == TIMEOUT−1 without mem_ready: abort. Rdata register <= 0, err set, go to DONE.
- DONE:
  - Pulse the owner's ack (and err if set) for exactly one cycle.
  - The owner's request is ignored this cycle.
  - Always go to IDLE.
- Streak counter (saturating, width clog2(STARVE_MAX+1)):
  - +1 on each DM grant made while if_req = 1.
  - Cleared on any IF grant, and on a DM grant while if_req = 0.
- dm_read & dm_write both high: treated as a write; err pulses with dm_ack.
- Requesters hold req, addr and wdata stable until they see ack. A request dropped mid-transaction does not abort the transaction.
- stall_if = if_req & ~if_ack; stall_mem = (dm_read|dm_write) & ~dm_ack. These are combinational from registered ack.
- When stall_mem = 1, the pipeline also holds IF; that is the pipeline's responsibility, not this block's.

## Timing
- Reset (async assert, sync deassert by the top level):
  - state = IDLE.
  - mem_en, mem_we, if_ack, dm_ack and err = 0.
  - if_rdata, dm_rdata, mem_addr, mem_wdata, streak and wdog = 0.
- Reset mid-transaction abandons it with no ack. The memory must tolerate mem_en dropping.
- Minimum latency with req sampled in IDLE at edge 0:
  - mem_en high in cycle 1.
  - With mem_ready in cycle 1, ack high in cycle 2 and IDLE in cycle 3.
  - Throughput is 1 transaction per 3 cycles at best.
- In general, ack is asserted at cycle 1 + (cycles to ready) + 1.
- wdog clears on entry to BUSY and increments each BUSY cycle. mem_ready in the same cycle as the timeout wins: normal completion, no err.
- Simultaneous if_req and DM request in IDLE: DM wins, subject to the streak rule.
- mem_ready outside BUSY is ignored.

## Structure
- Shared package mips_pkg:
  - arb_state_t enum {IDLE, BUSY_IF, BUSY_DM, DONE}.
  - Default ADDR_W/DATA_W constants.
  - Owner encoding constants OWN_IF/OWN_DM.
- Sub-module arb_watchdog: clear/enable inputs, parameter TIMEOUT, one-cycle expire output. The arbiter instantiates it once.
- All remaining logic (FSM, streak counter, latches, ack generation) lives in mem_port_arbiter.

## Test plan
- Reset, then if_req=1, addr 0x0040, memory ready after 1 cycle with 0x8C220004 → mem_en cycle 1, if_ack cycle 2, if_rdata=0x8C220004, stall_if low cycle 2.
- if_req and dm_read (addr 0x1000) both asserted at once → DM served first, if_ack follows dm_ack; stall_if held high throughout.
- dm_read held continuously with if_req=1 (STARVE_MAX=4) → 4 DM grants, then 1 IF grant, streak cleared.
- dm_write addr 0x2000 data 0xDEADBEEF, ready after 5 cycles → mem_we=1, addr and data stable all 5 cycles, dm_ack with err=0, dm_rdata unchanged.
- No mem_ready for TIMEOUT=64 → abort at BUSY cycle 64, ack+err pulse, rdata=0. Separately: ready at cycle 64 exactly → no err.
- rst_n low mid-BUSY_DM → all outputs 0 immediately, no ack; after release the next request is served normally.
